// File: rtl/fetch_sequencer_pkg.sv
// rtl/fetch_sequencer_pkg.sv - shared opcodes and state encoding for the fetch sequencer
//   Contents: OP_* opcode constants and the state_t enum (S_FETCH / S_EXEC / S_HALTED).
package fetch_sequencer_pkg;

  localparam logic [3:0] OP_JC   = 4'h0;
  localparam logic [3:0] OP_JNC  = 4'h1;
  localparam logic [3:0] OP_JZ   = 4'h2;
  localparam logic [3:0] OP_JNZ  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

endpackage

// File: rtl/fetch_sequencer_jump_decode.sv
// rtl/fetch_sequencer_jump_decode.sv - combinational jump classification and condition evaluation
//   Ports: instr (opcode nibble), carry, zero (ALU flags)
//          is_jump (opcode is a two-byte jump), taken (jump condition holds)
module jump_decode
  import fetch_sequencer_pkg::*;
(
  input  logic [3:0] instr,
  input  logic       carry,
  input  logic       zero,
  output logic       is_jump,
  output logic       taken
);

  always_comb begin
    is_jump = 1'b1;
    taken   = 1'b0;
    case (instr)
      OP_JC:   taken = carry;
      OP_JNC:  taken = ~carry;
      OP_JZ:   taken = zero;
      OP_JNZ:  taken = ~zero;
      OP_JMP:  taken = 1'b1;
      default: is_jump = 1'b0;
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - two-phase fetch/execute controller for the 4-bit processor front end
//   Inputs : clock, reset (async, active-high), run, instr/operand (fetch register nibbles),
//            progbyte (ROM byte at current PC), carry/zero (ALU flags)
//   Outputs: en_fetch, en_pc, load_pc, load_addr, exec, phase, halted, retired
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  input  logic [3:0]        instr,
  input  logic [3:0]        operand,
  input  logic [7:0]        progbyte,
  input  logic              carry,
  input  logic              zero,
  output logic              en_fetch,
  output logic              en_pc,
  output logic              load_pc,
  output logic [ADDR_W-1:0] load_addr,
  output logic              exec,
  output logic              phase,
  output logic              halted,
  output logic [CNT_W-1:0]  retired
);

  state_t state;
  state_t state_next;
  logic   is_jump;
  logic   taken;

  jump_decode u_jump_decode (
    .instr   (instr),
    .carry   (carry),
    .zero    (zero),
    .is_jump (is_jump),
    .taken   (taken)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_FETCH:  state_next = run ? S_EXEC : S_FETCH;
      S_EXEC:   state_next = (instr == OP_HALT) ? S_HALTED : S_FETCH;
      S_HALTED: state_next = S_HALTED;
      default:  state_next = S_FETCH;
    endcase
  end

  // Outputs are forced low while reset is held so an instruction aborted
  // mid-EXEC cannot leave a strobe on the bus during the reset cycle.
  always_comb begin
    en_fetch  = 1'b0;
    en_pc     = 1'b0;
    load_pc   = 1'b0;
    load_addr = '0;
    exec      = 1'b0;
    phase     = 1'b0;
    halted    = 1'b0;
    if (!reset) begin
      case (state)
        S_FETCH: begin
          en_fetch = run;
          en_pc    = run;
        end
        S_EXEC: begin
          phase = 1'b1;
          if (is_jump) begin
            // The jump's low address byte is already on progbyte because
            // the PC advanced past the opcode byte during FETCH.
            load_pc = taken;
            en_pc   = ~taken;
            if (taken) begin
              load_addr = ADDR_W'({operand, progbyte});
            end
          end else if (instr != OP_HALT) begin
            exec = 1'b1;
          end
        end
        S_HALTED: begin
          phase  = 1'b1;
          halted = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Every EXEC cycle retires exactly one instruction, whatever follows it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retired <= '0;
    end else if (state == S_EXEC) begin
      retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - self-checking bench for fetch_sequencer with ROM/PC/fetch-register model
module tb_fetch_sequencer;

  localparam int ADDR_W = 12;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              run = 1'b0;
  logic [3:0]        instr;
  logic [3:0]        operand;
  logic [7:0]        progbyte;
  logic              carry = 1'b0;
  logic              zero = 1'b0;
  logic              en_fetch, en_pc, load_pc, exec, phase, halted;
  logic [ADDR_W-1:0] load_addr;
  logic [CNT_W-1:0]  retired;

  logic [7:0]        rom [0:4095];
  logic [ADDR_W-1:0] pc;
  logic [7:0]        fetch_reg;

  int tests = 0;
  int fails = 0;

  fetch_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .run(run), .instr(instr), .operand(operand),
    .progbyte(progbyte), .carry(carry), .zero(zero), .en_fetch(en_fetch),
    .en_pc(en_pc), .load_pc(load_pc), .load_addr(load_addr), .exec(exec),
    .phase(phase), .halted(halted), .retired(retired)
  );

  always #5 clock = ~clock;

  // Front-end datapath around the controller: PC, ROM and fetch register.
  assign progbyte = rom[pc];
  assign instr    = fetch_reg[7:4];
  assign operand  = fetch_reg[3:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc        <= '0;
      fetch_reg <= '0;
    end else begin
      if (load_pc)     pc <= load_addr;
      else if (en_pc)  pc <= pc + 12'd1;
      if (en_fetch)    fetch_reg <= progbyte;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Packed as {en_fetch, en_pc, load_pc, exec, phase, halted, load_addr}.
  task automatic check_outs(input string name, input logic ef, input logic ep, input logic el,
                            input logic [11:0] ea, input logic ex, input logic eph, input logic eh);
    check(name, {en_fetch, en_pc, load_pc, exec, phase, halted, load_addr},
          {ef, ep, el, ex, eph, eh, ea});
  endtask

  // Mutual exclusion of PC increment and PC load, every cycle out of reset.
  always @(negedge clock) begin
    #2;
    if (reset === 1'b0) check("pc_excl", {31'd0, en_pc & load_pc}, 32'd0);
  end

  // All tasks start just after a falling edge and end on the next one.
  task automatic do_reset();
    reset = 1'b1; run = 1'b1; carry = 1'b1; zero = 1'b1;
    #1;
    check_outs("reset_outs", 0, 0, 0, 12'h000, 0, 0, 0);
    check("reset_retired", retired, 0);
    @(negedge clock);
    reset = 1'b0; run = 1'b0;
  endtask

  task automatic fetch_cycle(input string name, input logic [11:0] exp_pc);
    run = 1'b1;
    #1;
    check({name, "_pc"}, pc, exp_pc);
    check_outs({name, "_fetch"}, 1, 1, 0, 12'h000, 0, 0, 0);
    @(negedge clock);
  endtask

  task automatic exec_cycle(input string name, input logic c, input logic z, input logic r,
                            input logic el, input logic ep, input logic ex, input logic [11:0] ea);
    carry = c; zero = z; run = r;
    #1;
    check_outs({name, "_exec"}, 0, ep, el, ea, ex, 1, 0);
    @(negedge clock);
    run = 1'b0;
  endtask

  typedef struct {
    logic [7:0]  b0, b1;
    logic        c, z;
    logic        e_load, e_enpc, e_exec;
    logic [11:0] e_addr, e_next;
  } vec_t;

  vec_t vecs[$];

  // Instruction-level reference model: architectural PC and retire count only.
  logic [11:0] mpc;
  int          mret;

  task automatic model_instr(input int stall);
    logic [7:0]  b;
    logic [3:0]  op;
    logic        c, z, is_j, tk;
    logic [11:0] tgt;
    check("rnd_retired", retired, mret);
    for (int s = 0; s < stall; s++) begin
      run = 1'b0; carry = 1'($urandom); zero = 1'($urandom);
      #1;
      check_outs("rnd_stall", 0, 0, 0, 12'h000, 0, 0, 0);
      @(negedge clock);
    end
    b = rom[mpc];
    fetch_cycle("rnd", mpc);
    mpc = mpc + 12'd1;
    op = b[7:4];
    c = 1'($urandom); z = 1'($urandom);
    is_j = (op <= 4'h3) || (op == 4'hE);
    tk = (op == 4'h0 && c) || (op == 4'h1 && !c) || (op == 4'h2 && z) ||
         (op == 4'h3 && !z) || (op == 4'hE);
    tgt = {b[3:0], rom[mpc]};
    exec_cycle("rnd", c, z, 1'($urandom), tk, is_j && !tk, !is_j, tk ? tgt : 12'h000);
    if (tk)        mpc = tgt;
    else if (is_j) mpc = mpc + 12'd1;
    mret++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
    @(negedge clock);

    // Plain instruction: fetch, execute strobe, next fetch at 0x001.
    do_reset();
    rom[0] = 8'h5A;
    fetch_cycle("t1", 12'h000);
    check("t1_instr", {instr, operand}, 8'h5A);
    exec_cycle("t1", 0, 0, 1, 0, 0, 1, 12'h000);
    check("t1_retired", retired, 1);
    fetch_cycle("t1_next", 12'h001);

    // Unconditional jump to 0x345.
    do_reset();
    rom[0] = 8'hE3; rom[1] = 8'h45;
    fetch_cycle("t2", 12'h000);
    exec_cycle("t2", 0, 0, 1, 1, 0, 0, 12'h345);
    fetch_cycle("t2_target", 12'h345);

    // Table of single instructions placed at 0x010, reached by JMP 0x010.
    vecs.push_back('{8'h07, 8'h20, 0, 0, 0, 1, 0, 12'h000, 12'h012}); // JC   c=0
    vecs.push_back('{8'h07, 8'h20, 1, 0, 1, 0, 0, 12'h720, 12'h720}); // JC   c=1
    vecs.push_back('{8'h17, 8'h20, 0, 1, 1, 0, 0, 12'h720, 12'h720}); // JNC  c=0
    vecs.push_back('{8'h17, 8'h20, 1, 0, 0, 1, 0, 12'h000, 12'h012}); // JNC  c=1
    vecs.push_back('{8'h27, 8'h20, 1, 0, 0, 1, 0, 12'h000, 12'h012}); // JZ   z=0
    vecs.push_back('{8'h27, 8'h20, 0, 1, 1, 0, 0, 12'h720, 12'h720}); // JZ   z=1
    vecs.push_back('{8'h37, 8'h20, 1, 0, 1, 0, 0, 12'h720, 12'h720}); // JNZ  z=0
    vecs.push_back('{8'h37, 8'h20, 0, 1, 0, 1, 0, 12'h000, 12'h012}); // JNZ  z=1
    vecs.push_back('{8'hE7, 8'h20, 0, 0, 1, 0, 0, 12'h720, 12'h720}); // JMP
    vecs.push_back('{8'h5A, 8'h20, 1, 1, 0, 0, 1, 12'h000, 12'h011}); // ALU op
    vecs.push_back('{8'h40, 8'h99, 0, 1, 0, 0, 1, 12'h000, 12'h011}); // ALU op
    vecs.push_back('{8'hD3, 8'h01, 1, 0, 0, 0, 1, 12'h000, 12'h011}); // ALU op
    foreach (vecs[k]) begin
      do_reset();
      rom[0] = 8'hE0; rom[1] = 8'h10; rom[16] = vecs[k].b0; rom[17] = vecs[k].b1;
      fetch_cycle("tv_pre", 12'h000);
      exec_cycle("tv_pre", 0, 0, 1, 1, 0, 0, 12'h010);
      fetch_cycle($sformatf("tv%0d", k), 12'h010);
      exec_cycle($sformatf("tv%0d", k), vecs[k].c, vecs[k].z, 1,
                 vecs[k].e_load, vecs[k].e_enpc, vecs[k].e_exec, vecs[k].e_addr);
      #1;
      check($sformatf("tv%0d_nextpc", k), pc, vecs[k].e_next);
      check($sformatf("tv%0d_retired", k), retired, 2);
      @(negedge clock);
    end

    // HALT: sticky for 20+ cycles with run high, cleared only by reset.
    do_reset();
    rom[0] = 8'hF0;
    fetch_cycle("t4", 12'h000);
    exec_cycle("t4", 1, 1, 1, 0, 0, 0, 12'h000);
    run = 1'b1;
    for (int i = 0; i < 22; i++) begin
      #1;
      check_outs("t4_halted", 0, 0, 0, 12'h000, 0, 1, 1);
      @(negedge clock);
    end
    check("t4_retired", retired, 1);
    do_reset();
    #1;
    check("t4_cleared", {halted, phase, retired}, 0);
    @(negedge clock);

    // run=0 stall in FETCH, run dropped during EXEC does not stall.
    do_reset();
    rom[0] = 8'h61; rom[1] = 8'h72;
    for (int i = 0; i < 5; i++) begin
      run = 1'b0;
      #1;
      check_outs("t5_stall", 0, 0, 0, 12'h000, 0, 0, 0);
      check("t5_pc", pc, 12'h000);
      @(negedge clock);
    end
    fetch_cycle("t5", 12'h000);
    exec_cycle("t5", 0, 0, 0, 0, 0, 1, 12'h000);
    #1;
    check_outs("t5_after", 0, 0, 0, 12'h000, 0, 0, 0);
    check("t5_retired", retired, 1);
    @(negedge clock);

    // Async reset in the middle of a taken JMP's EXEC cycle.
    do_reset();
    rom[0] = 8'h5A; rom[1] = 8'hE3; rom[2] = 8'h45;
    fetch_cycle("t6a", 12'h000);
    exec_cycle("t6a", 0, 0, 1, 0, 0, 1, 12'h000);
    fetch_cycle("t6b", 12'h001);
    run = 1'b1;
    #1;
    check_outs("t6_jmp", 0, 0, 1, 12'h345, 0, 1, 0);
    #1;
    reset = 1'b1;
    #1;
    check_outs("t6_abort", 0, 0, 0, 12'h000, 0, 0, 0);
    check("t6_retired", retired, 0);
    @(negedge clock);
    reset = 1'b0; run = 1'b0;
    fetch_cycle("t6_restart", 12'h000);
    exec_cycle("t6_restart", 0, 0, 1, 0, 0, 1, 12'h000);

    // Randomised 200-instruction program (no HALT) against the model.
    for (int i = 0; i < 4096; i++) begin
      automatic logic [7:0] t = 8'($urandom);
      if (t[7:4] == 4'hF) t[7:4] = 4'h6;
      rom[i] = t;
    end
    do_reset();
    mpc = 12'h000;
    mret = 0;
    for (int n = 0; n < 200; n++) model_instr(int'($urandom_range(0, 2)));
    #1;
    check("rnd_final_retired", retired, mret);
    check("rnd_final_pc", pc, mpc);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
